// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the button input conditioner.
// Channel FSM states plus a counter-width helper.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REPEAT,
        ST_BLOCKED
    } chan_state_e;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_btn_channel.sv
// One button channel: 2-flop synchroniser, debouncer and
// press/repeat FSM producing a registered command pulse.
module btn_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    input  logic conflict,
    output logic btn_level,
    output logic pulse
);

    localparam int DBW  = cnt_w(DEBOUNCE_CYCLES - 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = cnt_w(RMAX);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RDELAY  = RCW'(REPEAT_DELAY);
    localparam logic [RCW-1:0] RRATE   = RCW'(REPEAT_RATE);
    localparam logic [RCW-1:0] RSAT    = RCW'(RMAX);

    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    chan_state_e    state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d, rinc;
    logic           pulse_q, pulse_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rinc = (rcnt_q == RSAT) ? rcnt_q : rcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    if (conflict) begin
                        state_d = ST_BLOCKED;
                    end else begin
                        pulse_d = 1'b1;
                        state_d = ST_WAIT;
                        rcnt_d  = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (conflict) begin
                    state_d = ST_BLOCKED;
                end else if (repeat_en) begin
                    if (rinc >= RDELAY) begin
                        pulse_d = 1'b1;
                        state_d = ST_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rinc;
                    end
                end
            end
            ST_REPEAT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (conflict) begin
                    state_d = ST_BLOCKED;
                end else if (!repeat_en) begin
                    // parked at the delay so re-enable repeats at once
                    state_d = ST_WAIT;
                    rcnt_d  = RDELAY;
                end else if (rinc >= RRATE) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rinc;
                end
            end
            ST_BLOCKED: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= ST_IDLE;
            rcnt_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign pulse     = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Button front end: per-channel conditioning, multi-press conflict
// guard, last-selection tracking and the new-game pulse path.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int MAX_ACTIVE      = 1,
    parameter int NG_DELAY        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    input  logic               start_new_game,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               conflict,
    output logic [NUM_BTN-1:0] last_sel,
    output logic               new_game_pulse,
    output logic               new_game_late
);

    logic [NUM_BTN-1:0]  chan_pulse;
    logic                conflict_q, conflict_d;
    logic [NUM_BTN-1:0]  last_sel_q, last_sel_d;
    logic                ng_s1_q, ng_s2_q, ng_s3_q;
    logic                ng_pulse_q, ng_pulse_d;
    logic [NG_DELAY-1:0] ng_sr_q, ng_sr_d;
    int                  active;
    logic                found;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .repeat_en(repeat_en[i]),
            .conflict (conflict_q),
            .btn_level(btn_level[i]),
            .pulse    (chan_pulse[i])
        );
    end

    // a pulse already in flight when conflict rises is swallowed here
    assign btn_pulse = chan_pulse & {NUM_BTN{~conflict_q}};

    always_comb begin
        active = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            active = active + (btn_level[i] ? 1 : 0);
        end
        conflict_d = (active > MAX_ACTIVE);
    end

    always_comb begin
        last_sel_d = last_sel_q;
        found      = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_pulse[i] && !found) begin
                last_sel_d    = '0;
                last_sel_d[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        ng_pulse_d = ng_s2_q & ~ng_s3_q;
        ng_sr_d    = (ng_sr_q << 1) | NG_DELAY'(ng_pulse_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 1'b0;
            last_sel_q <= '0;
            ng_s1_q    <= 1'b0;
            ng_s2_q    <= 1'b0;
            ng_s3_q    <= 1'b0;
            ng_pulse_q <= 1'b0;
            ng_sr_q    <= '0;
        end else begin
            conflict_q <= conflict_d;
            last_sel_q <= last_sel_d;
            ng_s1_q    <= start_new_game;
            ng_s2_q    <= ng_s1_q;
            ng_s3_q    <= ng_s2_q;
            ng_pulse_q <= ng_pulse_d;
            ng_sr_q    <= ng_sr_d;
        end
    end

    assign conflict       = conflict_q;
    assign last_sel       = last_sel_q;
    assign new_game_pulse = ng_pulse_q;
    assign new_game_late  = ng_sr_q[NG_DELAY-1];

endmodule
